// File: rtl/hilo_muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning all HI/LO writes, with pipeline stall on collisions.
// Optional build macro MULDIV_EARLY_TERM_EN: MUL finishes once the remaining multiplier bits are zero.
module hilo_muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_lo_read,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic [1:0]       hi_lo_write
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   rem;
  logic               neg_lo;
  logic               neg_hi;
  logic               is_mul;

  logic               accept;
  logic               is_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic               take;
  logic               mul_last;
  logic [2*WIDTH-1:0] prod_fix;

  always_comb begin
    accept    = start & ((state == S_IDLE) | (state == S_DONE));
    is_signed = ~op[0];
    a_mag     = (is_signed & a[WIDTH-1]) ? -a : a;
    b_mag     = (is_signed & b[WIDTH-1]) ? -b : b;
    // Restoring step: a non-negative trial difference sets the quotient bit.
    rem_sh    = {rem, quo[WIDTH-1]};
    diff      = rem_sh - {1'b0, divisor};
    take      = ~diff[WIDTH];
`ifdef MULDIV_EARLY_TERM_EN
    mul_last  = (cnt == LAST) | (mplier[WIDTH-1:1] == '0);
`else
    mul_last  = (cnt == LAST);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      mcand   <= '0;
      prod    <= '0;
      mplier  <= '0;
      quo     <= '0;
      divisor <= '0;
      rem     <= '0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      is_mul  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state   <= op[1] ? S_DIV : S_MUL;
            cnt     <= '0;
            mcand   <= {{WIDTH{1'b0}}, a_mag};
            mplier  <= b_mag;
            prod    <= '0;
            quo     <= a_mag;
            divisor <= b_mag;
            rem     <= '0;
            is_mul  <= ~op[1];
            // Divide by zero keeps the all-ones quotient unnegated.
            neg_lo  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]) & ~(op[1] & (b == '0));
            neg_hi  <= is_signed & a[WIDTH-1];
          end else begin
            state <= S_IDLE;
          end
        end
        S_MUL: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (mul_last) state <= S_DONE;
        end
        S_DIV: begin
          rem <= take ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], take};
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    prod_fix    = neg_lo ? -prod : prod;
    hi_out      = is_mul ? prod_fix[2*WIDTH-1:WIDTH] : (neg_hi ? -rem : rem);
    lo_out      = is_mul ? prod_fix[WIDTH-1:0] : (neg_lo ? -quo : quo);
    busy        = (state == S_MUL) | (state == S_DIV);
    done        = (state == S_DONE);
    stall       = busy & (hi_lo_read | start);
    hi_lo_write = {2{done}};
  end

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Bench for hilo_muldiv_sequencer: cycle-level reference model with per-cycle compare,
// plus directed cases with literal expectations. Honours MULDIV_EARLY_TERM_EN for latencies.
module tb_hilo_muldiv_sequencer;
  localparam int W = 32;

`ifdef MULDIV_EARLY_TERM_EN
  localparam int LAT_MN35 = 4;
  localparam int LAT_35   = 4;
  localparam int LAT_70   = 2;
  localparam logic [1:0]  COL_OP = 2'b11;
  localparam logic [31:0] COL_A  = 32'd6;
  localparam logic [31:0] COL_B  = 32'd1;
`else
  localparam int LAT_MN35 = 33;
  localparam int LAT_35   = 33;
  localparam int LAT_70   = 33;
  localparam logic [1:0]  COL_OP = 2'b01;
  localparam logic [31:0] COL_A  = 32'd2;
  localparam logic [31:0] COL_B  = 32'd3;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         hi_lo_read = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, stall, done;
  logic [W-1:0] hi_out, lo_out;
  logic [1:0]   hi_lo_write;

  int vectors = 0;
  int miscompares = 0;

  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  hilo_muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_lo_read(hi_lo_read), .busy(busy), .stall(stall), .done(done),
    .hi_out(hi_out), .lo_out(lo_out), .hi_lo_write(hi_lo_write)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
    longint sx, sy;
    int qs, rs;
    case (o)
      2'b00: begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return sx * sy;
      end
      2'b01: return {32'b0, x} * {32'b0, y};
      2'b10: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        qs = $signed(x) / $signed(y);
        rs = $signed(x) % $signed(y);
        return {rs, qs};
      end
      default: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  function automatic int iters(input logic [1:0] o, input logic [31:0] y);
    int n;
    logic [31:0] mag;
    n = 32;
`ifdef MULDIV_EARLY_TERM_EN
    if (!o[1]) begin
      mag = (!o[0] && y[31]) ? -y : y;
      n = 1;
      for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
    end
`else
    mag = y;
    if (o[1] && mag == 32'h0) n = 32;
`endif
    return n;
  endfunction

  // Reference model: inputs are stable across the negedge and sampled by the following posedge.
  always @(negedge clk) begin
    logic [63:0] r;
    bit exp_busy;
    if (rst) begin
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst write", hi_lo_write, 0);
      chk("rst hi", hi_out, 0);
      chk("rst lo", lo_out, 0);
      m_left = 0;
      m_done = 1'b0;
    end else begin
      exp_busy = (m_left > 0);
      chk("busy", busy, exp_busy);
      chk("done", done, m_done);
      chk("stall", stall, exp_busy & (hi_lo_read | start));
      chk("write", hi_lo_write, m_done ? 2'b11 : 2'b00);
      if (m_done) begin
        chk("model hi", hi_out, m_hi);
        chk("model lo", lo_out, m_lo);
      end
      if (!exp_busy && start) begin
        r = ref_res(op, a, b);
        m_hi = r[63:32];
        m_lo = r[31:0];
        m_left = iters(op, b);
        m_done = 1'b0;
      end else if (exp_busy) begin
        m_left--;
        m_done = (m_left == 0);
      end else begin
        m_done = 1'b0;
      end
    end
  end

  task automatic wait_done(input int lat0, input int elat, input logic [31:0] eh,
                           input logic [31:0] el, input string name);
    int lat;
    bit seen;
    lat = lat0;
    seen = 1'b0;
    while (!seen) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      else if (lat >= 120) break;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    chk({name, " latency"}, seen ? lat : -1, elat);
    chk({name, " hi"}, hi_out, eh);
    chk({name, " lo"}, lo_out, el);
    chk({name, " write"}, hi_lo_write, 2'b11);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int elat, input logic [31:0] eh, input logic [31:0] el,
                        input string name);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    wait_done(1, elat, eh, el, name);
    @(posedge clk); #1;
    @(negedge clk);
    chk({name, " write after"}, hi_lo_write, 2'b00);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int pulses;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, LAT_MN35, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_m3x5");
    run_op(2'b11, 32'd100, 32'd7, 33, 32'd2, 32'd14, "divu_100_7");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
    run_op(2'b10, 32'd5, 32'd0, 33, 32'd5, 32'hFFFF_FFFF, "div_5_0");
    run_op(2'b11, 32'd5, 32'd0, 33, 32'd5, 32'hFFFF_FFFF, "divu_5_0");
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 33, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_m5_0");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000, "div_ovf");
    run_op(2'b01, 32'd3, 32'd5, LAT_35, 32'h0, 32'd15, "multu_3x5");
    run_op(2'b01, 32'd7, 32'd0, LAT_70, 32'h0, 32'h0, "multu_7x0");
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h1, "multu_max");
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 32'h0, "mult_min");

    // Collision: second Start and HiLoRead while busy, then back-to-back issue on DONE.
    @(posedge clk); #1;
    start = 1'b1; op = COL_OP; a = COL_A; b = COL_B;
    for (int c = 1; c <= 33; c++) begin
      @(posedge clk); #1;
      hi_lo_read = (c >= 5 && c <= 10);
      start = (c >= 5 && c <= 10) || (c == 33);
      if (c == 33) begin op = 2'b11; a = 32'd100; b = 32'd7; end
      else begin op = 2'b00; a = 32'd9; b = 32'd9; end
      @(negedge clk);
      if (c >= 5 && c <= 10) chk("collision stall", stall, 1);
      if (c == 33) begin
        chk("collision done", done, 1);
        chk("collision lo", lo_out, 32'd6);
        chk("collision hi", hi_out, 32'd0);
      end
    end
    @(posedge clk); #1;
    start = 1'b0; hi_lo_read = 1'b0;
    @(negedge clk);
    chk("b2b busy", busy, 1);
    @(posedge clk); #1;
    wait_done(2, 33, 32'd2, 32'd14, "b2b_divu");

    // Abort mid-divide with reset.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("abort busy", busy, 0);
    chk("abort write", hi_lo_write, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    repeat (40) @(negedge clk) if (done !== 1'b0) pulses++;
    chk("abort no done", pulses, 0);
    run_op(2'b10, 32'd1000, 32'd3, 33, 32'd1, 32'd333, "div_after_reset");

    for (int i = 0; i < 15000; i++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 999) == 0);
      start = ($urandom_range(0, 3) == 0);
      hi_lo_read = 1'($urandom_range(0, 1));
      op = 2'($urandom);
      a = pick();
      b = pick();
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; hi_lo_read = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
